// File: rtl/adc_chan_sequencer.sv
// Multi-channel AD7324 result sequencer: issues start pulses, validates result frames,
// converts to offset binary, optionally box-car averages and publishes per-channel values.
module adc_chan_sequencer #(
  parameter int N_CH     = 4,
  parameter int OUT_W    = 12,
  parameter int AVG_LOG2 = 0,
  parameter int TIMEOUT  = 1024
) (
  input  logic                   CLK,
  input  logic                   RSTp,
  input  logic                   en,
  input  logic                   err_clr,
  input  logic                   frame_valid,
  input  logic [15:0]            frame_data,
  output logic                   hold,
  output logic [N_CH*OUT_W-1:0]  ch_data,
  output logic [N_CH-1:0]        ch_valid,
  output logic                   upd_valid,
  output logic [1:0]             upd_ch,
  output logic [OUT_W-1:0]       upd_data,
  output logic                   fmt_err,
  output logic                   chid_err,
  output logic                   seq_err,
  output logic                   ovr_err,
  output logic                   tmo_err,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, PROC = 2'd3} state_t;

  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SW = OUT_W + AVG_LOG2;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << AVG_LOG2) - 1);

  state_t            state, state_nxt;
  logic [TW-1:0]     tmr;
  logic [15:0]       cap;
  logic [1:0]        exp_ch;
  logic [SW-1:0]     acc [4];
  logic [CW-1:0]     cnt [4];
  logic [OUT_W-1:0]  ch_reg [4];
  logic [3:0]        vld;

  logic              timeout_hit;
  logic [1:0]        id;
  logic [1:0]        id_nxt;
  logic [12:0]       off;
  logic [OUT_W-1:0]  sample;
  logic              is_proc, fmt_ev, chid_ev, accept, seq_ev, ovr_ev;
  logic [SW-1:0]     acc_sum;
  logic              wrap;
  logic [OUT_W-1:0]  avg_res;

  // frame_valid is a single-cycle strobe with no back-pressure: it is only taken in WAIT,
  // flagged as overrun in START/PROC, and silently ignored in IDLE.
  assign timeout_hit = (state == WAIT) && !frame_valid && en && (tmr == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RSTp) begin
    if (RSTp) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT: begin
        if (frame_valid)      state_nxt = PROC;
        else if (!en)         state_nxt = IDLE;
        else if (timeout_hit) state_nxt = START;
      end
      PROC:  state_nxt = en ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hold      = (state == START);
    state_dbg = state;
    is_proc   = (state == PROC);
  end

  // Captured-frame decode; the sample is the top OUT_W bits of the offset-binary value.
  assign id      = cap[14:13];
  assign off     = cap[12:0] ^ 13'h1000;
  assign sample  = off[12 -: OUT_W];
  assign id_nxt  = (int'(id) == N_CH - 1) ? 2'd0 : id + 2'd1;
  assign fmt_ev  = is_proc && cap[15];
  assign chid_ev = is_proc && !cap[15] && (int'(id) >= N_CH);
  assign accept  = is_proc && !cap[15] && (int'(id) < N_CH);
  assign seq_ev  = accept && (id != exp_ch);
  assign ovr_ev  = frame_valid && ((state == PROC) || (state == START));
  assign acc_sum = acc[id] + SW'(sample);
  assign wrap    = (cnt[id] == CNT_MAX);
  assign avg_res = OUT_W'(acc_sum >> AVG_LOG2);

  always_ff @(posedge CLK or posedge RSTp) begin
    if (RSTp) begin
      tmr       <= '0;
      cap       <= '0;
      exp_ch    <= '0;
      vld       <= '0;
      upd_valid <= 1'b0;
      upd_ch    <= '0;
      upd_data  <= '0;
      fmt_err   <= 1'b0;
      chid_err  <= 1'b0;
      seq_err   <= 1'b0;
      ovr_err   <= 1'b0;
      tmo_err   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        acc[k]    <= '0;
        cnt[k]    <= '0;
        ch_reg[k] <= '0;
      end
    end else begin
      tmr       <= (state == WAIT) ? tmr + TW'(1) : '0;
      upd_valid <= 1'b0;
      if ((state == WAIT) && frame_valid) cap <= frame_data;
      if (accept) begin
        exp_ch <= id_nxt;
        if (wrap) begin
          acc[id]    <= '0;
          cnt[id]    <= '0;
          ch_reg[id] <= avg_res;
          vld[id]    <= 1'b1;
          upd_valid  <= 1'b1;
          upd_ch     <= id;
          upd_data   <= avg_res;
        end else begin
          acc[id] <= acc_sum;
          cnt[id] <= cnt[id] + CW'(1);
        end
      end
      // A new event in the same cycle as err_clr leaves its flag set.
      fmt_err  <= (fmt_err  & ~err_clr) | fmt_ev;
      chid_err <= (chid_err & ~err_clr) | chid_ev;
      seq_err  <= (seq_err  & ~err_clr) | seq_ev;
      ovr_err  <= (ovr_err  & ~err_clr) | ovr_ev;
      tmo_err  <= (tmo_err  & ~err_clr) | timeout_hit;
    end
  end

  assign ch_valid = vld[N_CH-1:0];

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch_data[k*OUT_W +: OUT_W] = ch_reg[k];
  end

endmodule

// File: tb/tb_adc_chan_sequencer.sv
// Directed bench for adc_chan_sequencer: three instances cover the default 4-channel
// pass-through, a 3-channel/short-timeout error case and a 1-channel averaging case.
module tb_adc_chan_sequencer;

  logic CLK = 1'b0;
  logic RSTp = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  // u0: N_CH=4, OUT_W=12, AVG_LOG2=0, TIMEOUT=1024
  logic        en0 = 0, clr0 = 0, fv0 = 0;
  logic [15:0] fd0 = '0;
  logic        hold0, upd_valid0, fmt0, chid0, seq0, ovr0, tmo0;
  logic [47:0] ch_data0;
  logic [3:0]  ch_valid0;
  logic [1:0]  upd_ch0, st0;
  logic [11:0] upd_data0;

  adc_chan_sequencer #(.N_CH(4), .OUT_W(12), .AVG_LOG2(0), .TIMEOUT(1024)) u0 (
    .CLK(CLK), .RSTp(RSTp), .en(en0), .err_clr(clr0), .frame_valid(fv0), .frame_data(fd0),
    .hold(hold0), .ch_data(ch_data0), .ch_valid(ch_valid0), .upd_valid(upd_valid0),
    .upd_ch(upd_ch0), .upd_data(upd_data0), .fmt_err(fmt0), .chid_err(chid0),
    .seq_err(seq0), .ovr_err(ovr0), .tmo_err(tmo0), .state_dbg(st0));

  // u1: N_CH=3, TIMEOUT=16
  logic        en1 = 0, clr1 = 0, fv1 = 0;
  logic [15:0] fd1 = '0;
  logic        hold1, upd_valid1, fmt1, chid1, seq1, ovr1, tmo1;
  logic [35:0] ch_data1;
  logic [2:0]  ch_valid1;
  logic [1:0]  upd_ch1, st1;
  logic [11:0] upd_data1;

  adc_chan_sequencer #(.N_CH(3), .OUT_W(12), .AVG_LOG2(0), .TIMEOUT(16)) u1 (
    .CLK(CLK), .RSTp(RSTp), .en(en1), .err_clr(clr1), .frame_valid(fv1), .frame_data(fd1),
    .hold(hold1), .ch_data(ch_data1), .ch_valid(ch_valid1), .upd_valid(upd_valid1),
    .upd_ch(upd_ch1), .upd_data(upd_data1), .fmt_err(fmt1), .chid_err(chid1),
    .seq_err(seq1), .ovr_err(ovr1), .tmo_err(tmo1), .state_dbg(st1));

  // u2: N_CH=1, AVG_LOG2=2
  logic        en2 = 0, clr2 = 0, fv2 = 0;
  logic [15:0] fd2 = '0;
  logic        hold2, upd_valid2, fmt2, chid2, seq2, ovr2, tmo2;
  logic [11:0] ch_data2;
  logic [0:0]  ch_valid2;
  logic [1:0]  upd_ch2, st2;
  logic [11:0] upd_data2;

  adc_chan_sequencer #(.N_CH(1), .OUT_W(12), .AVG_LOG2(2), .TIMEOUT(1024)) u2 (
    .CLK(CLK), .RSTp(RSTp), .en(en2), .err_clr(clr2), .frame_valid(fv2), .frame_data(fd2),
    .hold(hold2), .ch_data(ch_data2), .ch_valid(ch_valid2), .upd_valid(upd_valid2),
    .upd_ch(upd_ch2), .upd_data(upd_data2), .fmt_err(fmt2), .chid_err(chid2),
    .seq_err(seq2), .ovr_err(ovr2), .tmo_err(tmo2), .state_dbg(st2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each send drives one frame strobe from WAIT and returns on the negedge after the PROC edge.
  task automatic send0(input logic [15:0] d);
    fd0 = d; fv0 = 1'b1; @(negedge CLK); fv0 = 1'b0; @(negedge CLK);
  endtask
  task automatic send1(input logic [15:0] d);
    fd1 = d; fv1 = 1'b1; @(negedge CLK); fv1 = 1'b0; @(negedge CLK);
  endtask
  task automatic send2(input logic [15:0] d);
    fd2 = d; fv2 = 1'b1; @(negedge CLK); fv2 = 1'b0; @(negedge CLK);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_hold", hold0, 0);
    chk("rst_ch_data", ch_data0, 0);
    chk("rst_ch_valid", ch_valid0, 0);
    chk("rst_upd", {upd_valid0, upd_ch0, upd_data0}, 0);
    chk("rst_errs", {fmt0, chid0, seq0, ovr0, tmo0}, 0);
    chk("rst_state", st0, 0);
    RSTp = 1'b0;
    @(negedge CLK);
    chk("idle_hold", hold0, 0);

    // start pulse: exactly one cycle
    en0 = 1'b1;
    @(negedge CLK);
    chk("start_hold_hi", hold0, 1);
    @(negedge CLK);
    chk("start_hold_lo", hold0, 0);
    chk("wait_state", st0, 2);

    // first frame, latency check
    fd0 = 16'h0000; fv0 = 1'b1;
    @(negedge CLK);
    fv0 = 1'b0;
    chk("lat_upd_early", upd_valid0, 0);
    @(negedge CLK);
    chk("lat_upd_valid", upd_valid0, 1);
    chk("ch0_upd_ch", upd_ch0, 0);
    chk("ch0_upd_data", upd_data0, 12'h800);
    send0(16'h3FFF);
    chk("ch1_upd_ch", upd_ch0, 1);
    chk("ch1_upd_data", upd_data0, 12'h7FF);
    send0(16'h4FFF);
    chk("ch2_upd_data", upd_data0, 12'hFFF);
    send0(16'h7000);
    chk("ch3_upd_data", upd_data0, 12'h000);
    chk("main_ch_data", ch_data0, 48'h000FFF7FF800);
    chk("main_ch_valid", ch_valid0, 4'hF);
    chk("main_errs", {fmt0, chid0, seq0, ovr0, tmo0}, 0);
    @(negedge CLK);
    chk("upd_pulse_width", upd_valid0, 0);

    // sequence error: ch0 then ch2
    send0(16'h0010);
    chk("seq_ok", seq0, 0);
    send0(16'h4020);
    chk("seq_err_set", seq0, 1);
    chk("seq_upd_ch", upd_ch0, 2);
    chk("seq_ch2_data", ch_data0[35:24], 12'h810);
    send0(16'h6000);
    chk("seq_ch3_upd", {upd_valid0, upd_ch0, upd_data0}, {1'b1, 2'd3, 12'h800});
    clr0 = 1'b1;
    @(negedge CLK);
    clr0 = 1'b0;
    chk("seq_cleared", seq0, 0);
    send0(16'h0000);
    chk("seq_wrap_ok", seq0, 0);

    // asynchronous reset during PROC
    fd0 = 16'h2000; fv0 = 1'b1;
    @(negedge CLK);
    fv0 = 1'b0;
    chk("proc_before_rst", st0, 3);
    RSTp = 1'b1;
    #1;
    chk("rst_proc_state", st0, 0);
    chk("rst_proc_ch_data", ch_data0, 0);
    chk("rst_proc_ch_valid", ch_valid0, 0);
    chk("rst_proc_upd", {upd_valid0, upd_ch0, upd_data0}, 0);
    en0 = 1'b0;
    @(negedge CLK);
    RSTp = 1'b0;
    @(negedge CLK);
    chk("rst_proc_after", {upd_valid0, ch_valid0}, 0);

    // u1: channel-ID / format errors, timeout, overrun, set-wins clear
    en1 = 1'b1;
    @(negedge CLK);
    chk("u1_hold", hold1, 1);
    @(negedge CLK);
    send1(16'h6000);
    chk("chid_err", chid1, 1);
    chk("chid_no_upd", upd_valid1, 0);
    send1(16'h8000);
    chk("fmt_err", fmt1, 1);
    chk("fmt_no_upd", upd_valid1, 0);
    chk("u1_ch_valid", ch_valid1, 0);
    repeat (15) @(negedge CLK);
    chk("tmo_hold_early", hold1, 0);
    chk("tmo_err_early", tmo1, 0);
    @(negedge CLK);
    chk("tmo_hold", hold1, 1);
    chk("tmo_err", tmo1, 1);
    @(negedge CLK);
    fd1 = 16'h0000; fv1 = 1'b1;
    @(negedge CLK);
    fd1 = 16'h2000; clr1 = 1'b1;
    @(negedge CLK);
    fv1 = 1'b0; clr1 = 1'b0;
    chk("ovr_err", ovr1, 1);
    chk("clr_others", {fmt1, chid1, seq1, tmo1}, 0);
    chk("ovr_upd", {upd_valid1, upd_ch1, upd_data1}, {1'b1, 2'd0, 12'h800});
    @(negedge CLK);
    chk("ovr_ignored_upd", upd_valid1, 0);
    chk("ovr_ignored_state", st1, 2);
    en1 = 1'b0;

    // u2: averaging of 4 samples
    en2 = 1'b1;
    repeat (2) @(negedge CLK);
    send2(16'h0000);
    chk("avg_n1", upd_valid2, 0);
    send2(16'h0004);
    chk("avg_n2", upd_valid2, 0);
    send2(16'h0008);
    chk("avg_n3", upd_valid2, 0);
    send2(16'h000C);
    chk("avg_pub", {upd_valid2, upd_data2}, {1'b1, 12'h803});
    chk("avg_ch_data", ch_data2, 12'h803);
    chk("avg_ch_valid", ch_valid2, 1);
    send2(16'h1000);
    send2(16'h1002);
    send2(16'h1004);
    chk("avg2_n3", upd_valid2, 0);
    send2(16'h1008);
    chk("avg2_pub", {upd_valid2, upd_data2}, {1'b1, 12'h001});
    chk("avg2_errs", {fmt2, chid2, seq2, ovr2, tmo2}, 0);
    en2 = 1'b0;

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_chan_sequencer.md
Name: adc_chan_sequencer

Overview:
- Parametrised multi-channel successor to the single-shot ADC read logic.
- Issues the start (hold) pulse to the SPI AD7324 interface, accepts 16-bit result frames and checks frame format, channel ID and channel sequence.
- Converts two's-complement error data to offset binary, truncates it to a configurable resolution, optionally box-car averages it, and publishes per-channel registers plus an update strobe for the compensator and LCD logic.

Parameters:
- N_CH, 4, channels in use (1..4); channel IDs 0..N_CH-1 are legal.
- OUT_W, 12, output resolution in bits (1..13); takes the top OUT_W bits of the 13-bit offset-binary value.
- AVG_LOG2, 0, average 2^AVG_LOG2 samples per channel (0..4); 0 means pass-through.
- TIMEOUT, 1024, cycles to wait for a frame before re-issuing start (>= 2).

Ports:
- CLK  in  1  system clock (20 MHz domain of the SPI block).
- RSTp  in  1  asynchronous, active-high reset.
- en  in  1  run enable.
- err_clr  in  1  one-cycle pulse; clears sticky errors.
- frame_valid  in  1  one-cycle pulse; frame_data is valid.
- frame_data  in  16  [15]=0 leading bit, [14:13] channel ID, [12:0] two's-complement data.
- hold  out  1  one-cycle start pulse to the SPI block.
- ch_data  out  N_CH*OUT_W  packed channel results; channel k occupies [k*OUT_W +: OUT_W].
- ch_valid  out  N_CH  set on a channel's first published result.
- upd_valid  out  1  one-cycle pulse when a channel result is published.
- upd_ch  out  2  channel of the last publish.
- upd_data  out  OUT_W  value of the last publish.
- fmt_err, chid_err, seq_err, ovr_err, tmo_err  out  1 each  sticky error flags.

Behaviour:
- Reset (asynchronous, RSTp=1): every output 0, FSM in IDLE, accumulators, sample counters and expected-channel register 0. Asserting RSTp mid-frame abandons that frame.
- FSM states: IDLE, START, WAIT, PROC.
  - IDLE: go to START when en=1.
  - START: hold=1 for exactly this cycle; go to WAIT.
  - WAIT: on frame_valid, capture frame_data and go to PROC. If TIMEOUT cycles elapse with no frame, set tmo_err and go to START. If en=0, go to IDLE.
  - PROC: process the captured frame (one cycle); go to WAIT if en=1, else IDLE.
- Frame checks, applied in priority order:
  - frame_data[15]=1: set fmt_err and drop the frame.
  - ID >= N_CH: set chid_err and drop the frame.
  - ID != expected channel: set seq_err, process the frame anyway, and resynchronise expected to ID+1.
  - The expected channel advances as (ID+1) mod N_CH after every accepted frame.
- Conversion: the 13-bit offset-binary value is data XOR 13'h1000 (that is, data + 2^12 mod 2^13). The sample is bits [12:13-OUT_W] of that value, truncated with no rounding.
- Averaging (AVG_LOG2>0):
  - Each channel has an (OUT_W+AVG_LOG2)-bit accumulator and an AVG_LOG2-bit counter.
  - Every accepted sample is added to its channel's accumulator.
  - When the counter wraps to 0, the result is acc >> AVG_LOG2, published, and the accumulator is cleared in the same cycle.
  - Below the wrap, nothing is published.
- Publish: happens on the PROC clock edge.
  - ch_data slice, ch_valid bit, upd_ch and upd_data are updated.
  - upd_valid is high for the following cycle only.
  - Latency is 2 cycles from the frame_valid edge to upd_valid high.
- Overrun: frame_valid while in PROC or START sets ovr_err; that frame is ignored.
- Sticky errors:
  - err_clr clears all of them.
  - If err_clr coincides with a new error event, the flag ends up set (set wins).
- en deassert: the current PROC completes. Channel registers and ch_valid are retained while idle.

Test Plan:
- Reset, en=1 -> hold pulses once in the cycle after IDLE->START, exactly 1 cycle wide; all outputs 0 before that.
- N_CH=4, OUT_W=12, AVG_LOG2=0; frames 0x0000, 0x3FFF, 0x4FFF, 0x7000 -> ch0=0x800, ch1=0x7FF, ch2=0xFFF, ch3=0x000; upd_valid 2 cycles after each frame_valid; ch_valid=4'hF; no errors.
- Frame sequence ch0, ch2 -> seq_err=1 and ch2 still updated. Then frame ch3 -> no further error. Then err_clr -> seq_err=0.
- N_CH=3, frame 0x6000 -> chid_err=1, no upd_valid. Frame 0x8000 -> fmt_err=1, dropped.
- AVG_LOG2=2, OUT_W=12, N_CH=1; ch0 data giving 0x800, 0x802, 0x804, 0x806 -> exactly one upd_valid after the 4th frame with upd_data=0x803; the next 4 samples average independently.
- TIMEOUT=16, no frames -> tmo_err set and hold re-pulses 16 cycles after WAIT entry. frame_valid in PROC -> ovr_err=1. RSTp asserted during PROC -> outputs 0 immediately.
